// File: rtl/nand_pkg.sv
// nand_pkg: command opcodes, backend op codes, target FSM states, status bit positions
// and pin-synchronizer lane indices shared by the nand_target slice.
package nand_pkg;

   localparam logic [7:0] CMD_READ     = 8'h00;
   localparam logic [7:0] CMD_READ_GO  = 8'h30;
   localparam logic [7:0] CMD_PROG     = 8'h80;
   localparam logic [7:0] CMD_PROG_GO  = 8'h10;
   localparam logic [7:0] CMD_ERASE    = 8'h60;
   localparam logic [7:0] CMD_ERASE_GO = 8'hD0;
   localparam logic [7:0] CMD_STATUS   = 8'h70;
   localparam logic [7:0] CMD_READID   = 8'h90;
   localparam logic [7:0] CMD_RESET    = 8'hFF;

   localparam logic [1:0] OP_READ  = 2'd0;
   localparam logic [1:0] OP_PROG  = 2'd1;
   localparam logic [1:0] OP_ERASE = 2'd2;

   localparam int STAT_WP_BIT   = 7;
   localparam int STAT_RDY_BIT  = 6;
   localparam int STAT_FAIL_BIT = 0;

   // Synchronizer lanes {nwp, nre, nwe, ale, cle, nce}; idle value has all active-low pins high.
   localparam int PIN_NCE = 0;
   localparam int PIN_CLE = 1;
   localparam int PIN_ALE = 2;
   localparam int PIN_NWE = 3;
   localparam int PIN_NRE = 4;
   localparam int PIN_NWP = 5;
   localparam logic [5:0] PIN_IDLE = 6'b111001;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADDR = 3'd1,
      ST_DIN  = 3'd2,
      ST_BUSY = 3'd3,
      ST_DOUT = 3'd4,
      ST_STAT = 3'd5,
      ST_ID   = 3'd6
   } state_t;

   typedef enum logic [1:0] {
      PEND_READ  = 2'd0,
      PEND_PROG  = 2'd1,
      PEND_ERASE = 2'd2,
      PEND_ID    = 2'd3
   } pend_t;

   function automatic logic [7:0] status_byte(input logic wp, input logic rdy, input logic fail);
      logic [7:0] s;
      s = 8'h00;
      s[STAT_WP_BIT]   = wp;
      s[STAT_RDY_BIT]  = rdy;
      s[STAT_FAIL_BIT] = fail;
      return s;
   endfunction

endpackage

// File: rtl/nand_pin_sync.sv
// nand_pin_sync: 2-FF synchronizers for the flash strobes plus nWE-rise and nRE-fall/rise
// pulses derived from the synchronized level against its one-cycle delay.
module nand_pin_sync
   import nand_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic nce_pin,
   input  logic cle_pin,
   input  logic ale_pin,
   input  logic nwe_pin,
   input  logic nre_pin,
   input  logic nwp_pin,
   output logic nce,
   output logic cle,
   output logic ale,
   output logic nre,
   output logic nwp,
   output logic we_rise,
   output logic re_fall,
   output logic re_rise
);

   logic [5:0] meta_r;
   logic [5:0] sync_r;
   logic       nwe_d_r;
   logic       nre_d_r;

   // Two-stage synchronizer and edge-detect delay taps.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_r  <= PIN_IDLE;
         sync_r  <= PIN_IDLE;
         nwe_d_r <= 1'b1;
         nre_d_r <= 1'b1;
      end else begin
         meta_r  <= {nwp_pin, nre_pin, nwe_pin, ale_pin, cle_pin, nce_pin};
         sync_r  <= meta_r;
         nwe_d_r <= sync_r[PIN_NWE];
         nre_d_r <= sync_r[PIN_NRE];
      end
   end

   assign nce     = sync_r[PIN_NCE];
   assign cle     = sync_r[PIN_CLE];
   assign ale     = sync_r[PIN_ALE];
   assign nre     = sync_r[PIN_NRE];
   assign nwp     = sync_r[PIN_NWP];
   assign we_rise = sync_r[PIN_NWE] & ~nwe_d_r;
   assign re_fall = ~sync_r[PIN_NRE] & nre_d_r;
   assign re_rise = sync_r[PIN_NRE] & ~nre_d_r;

endmodule

// File: rtl/nand_target.sv
// nand_target: ONFI-style NAND device-side responder with page buffer and backend handshake.
// Define NAND_TGT_WP_EN to let F_nWP low block program and erase.
module nand_target
   import nand_pkg::*;
#(
   parameter int          PAGE_BYTES = 64,
   parameter logic [39:0] ID_BYTES   = 40'h00_00_95_DA_EC,
   parameter int          RST_CYCLES = 16
) (
   input  logic                          PCLK,
   input  logic                          PRESET,
   input  logic                          F_nCE,
   input  logic                          F_CLE,
   input  logic                          F_ALE,
   input  logic                          F_nWE,
   input  logic                          F_nRE,
   input  logic                          F_nWP,
   input  logic [7:0]                    F_DIO_in,
   output logic [7:0]                    F_DIO_out,
   output logic                          F_DIO_oe,
   output logic                          F_nRB,
   output logic                          B_Req,
   output logic [1:0]                    B_Op,
   output logic [39:0]                   B_Addr,
   input  logic                          B_Ack,
   input  logic                          B_Fail,
   input  logic [$clog2(PAGE_BYTES)-1:0] B_BufAddr,
   input  logic [7:0]                    B_BufWData,
   input  logic                          B_BufWe,
   output logic [7:0]                    B_BufRData
);

   localparam int AW = $clog2(PAGE_BYTES);
   localparam int RW = $clog2(RST_CYCLES + 1);

   logic nce_s, cle_s, ale_s, nre_s, nwp_s, we_rise_s, re_fall_s, re_rise_s;
   logic wp_block_s, wp_bit_s, gate_s, rd_go_s, pg_go_s, er_go_s, hwe_s;

   state_t        state_r, state_n;
   pend_t         pend_r, pend_n;
   logic [2:0]    acnt_r, acnt_n, idptr_r, idptr_n;
   logic [39:0]   addr_r, addr_n;
   logic [AW-1:0] ptr_r, ptr_n;
   logic [RW-1:0] rcnt_r, rcnt_n;
   logic [1:0]    bop_r, bop_n;
   logic [7:0]    dout_r, dout_n;
   logic          busy_r, busy_n, fail_r, fail_n, oe_r, oe_n, nrb_r, nrb_n;
   logic [7:0]    buf_r [PAGE_BYTES];

   nand_pin_sync u_sync (
      .clk(PCLK), .rst(PRESET),
      .nce_pin(F_nCE), .cle_pin(F_CLE), .ale_pin(F_ALE),
      .nwe_pin(F_nWE), .nre_pin(F_nRE), .nwp_pin(F_nWP),
      .nce(nce_s), .cle(cle_s), .ale(ale_s), .nre(nre_s), .nwp(nwp_s),
      .we_rise(we_rise_s), .re_fall(re_fall_s), .re_rise(re_rise_s)
   );

`ifdef NAND_TGT_WP_EN
   assign wp_block_s = ~nwp_s;
`else
   logic unused_nwp_s;
   assign unused_nwp_s = nwp_s;
   assign wp_block_s   = 1'b0;
`endif
   assign wp_bit_s = ~wp_block_s;
   // While an op or the reset timer runs, only status and reset commands are honoured.
   assign gate_s  = busy_r | (rcnt_r != '0);
   assign rd_go_s = (state_r == ST_ADDR) && (pend_r == PEND_READ) && (acnt_r == 3'd5);
   assign pg_go_s = (state_r == ST_DIN) && (pend_r == PEND_PROG) && !wp_block_s;
   assign er_go_s = (state_r == ST_ADDR) && (pend_r == PEND_ERASE) && (acnt_r == 3'd5) && !wp_block_s;

   // Next-state decode: backend completion, latch cycles, chip deselect and read strobes.
   always_comb begin
      state_n = state_r;  pend_n = pend_r;  acnt_n = acnt_r;  addr_n = addr_r;
      ptr_n   = ptr_r;    idptr_n = idptr_r; busy_n = busy_r; bop_n  = bop_r;
      fail_n  = fail_r;   dout_n = dout_r;  hwe_s  = 1'b0;
      rcnt_n  = (rcnt_r != '0) ? rcnt_r - RW'(1) : rcnt_r;
      if (busy_r && B_Ack) begin
         busy_n = 1'b0;
         fail_n = B_Fail;
         if (state_r == ST_BUSY) begin
            state_n = (bop_r == OP_READ) ? ST_DOUT : ST_IDLE;
            ptr_n   = addr_r[AW-1:0];
         end else begin
            state_n = state_r;
         end
      end else begin
         busy_n = busy_r;
      end
      if (we_rise_s && !nce_s) begin
         if (cle_s && !ale_s) begin
            if (F_DIO_in == CMD_RESET) begin
               state_n = ST_IDLE;
               busy_n  = 1'b0;
               fail_n  = 1'b0;
               rcnt_n  = RW'(RST_CYCLES);
            end else if (F_DIO_in == CMD_STATUS) begin
               state_n = ST_STAT;
            end else if (gate_s) begin
               state_n = state_n;
            end else begin
               case (F_DIO_in)
                  CMD_READ:   begin state_n = ST_ADDR; pend_n = PEND_READ;  acnt_n = 3'd0; addr_n = 40'd0; end
                  CMD_PROG:   begin state_n = ST_ADDR; pend_n = PEND_PROG;  acnt_n = 3'd0; addr_n = 40'd0; end
                  CMD_ERASE:  begin state_n = ST_ADDR; pend_n = PEND_ERASE; acnt_n = 3'd2; addr_n = 40'd0; end
                  CMD_READID: begin state_n = ST_ADDR; pend_n = PEND_ID;    acnt_n = 3'd0; end
                  CMD_READ_GO:  begin state_n = rd_go_s ? ST_BUSY : ST_IDLE; busy_n = rd_go_s;
                                      bop_n = rd_go_s ? OP_READ : bop_r; end
                  CMD_PROG_GO:  begin state_n = pg_go_s ? ST_BUSY : ST_IDLE; busy_n = pg_go_s;
                                      bop_n = pg_go_s ? OP_PROG : bop_r; end
                  CMD_ERASE_GO: begin state_n = er_go_s ? ST_BUSY : ST_IDLE; busy_n = er_go_s;
                                      bop_n = er_go_s ? OP_ERASE : bop_r; end
                  default:    state_n = ST_IDLE;
               endcase
            end
         end else if (gate_s || (cle_s && ale_s)) begin
            state_n = state_n;
         end else if (ale_s) begin
            if ((state_r == ST_ADDR) && (pend_r == PEND_ID)) begin
               state_n = ST_ID;
               idptr_n = 3'd0;
            end else if ((state_r == ST_ADDR) && (acnt_r < 3'd5)) begin
               addr_n[{acnt_r, 3'b000} +: 8] = F_DIO_in;
               acnt_n = acnt_r + 3'd1;
               if ((acnt_r == 3'd4) && (pend_r == PEND_PROG)) begin
                  state_n = ST_DIN;
                  ptr_n   = addr_r[AW-1:0];
               end else begin
                  state_n = ST_ADDR;
               end
            end else begin
               state_n = ST_IDLE;
            end
         end else if (state_r == ST_DIN) begin
            hwe_s = !wp_block_s;
            ptr_n = ptr_r + AW'(1);
         end else begin
            state_n = ST_IDLE;
         end
      end else if (nce_s) begin
         case (state_r)
            ST_ADDR, ST_DIN, ST_DOUT, ST_ID: state_n = ST_IDLE;
            ST_STAT: state_n = busy_n ? ST_BUSY : ST_IDLE;
            default: state_n = state_n;
         endcase
      end else begin
         state_n = state_n;
      end
      if (re_fall_s) begin
         case (state_r)
            ST_DOUT: dout_n = buf_r[ptr_r];
            ST_STAT: dout_n = status_byte(wp_bit_s, nrb_r, fail_r);
            ST_ID:   dout_n = ID_BYTES[{idptr_r, 3'b000} +: 8];
            default: dout_n = dout_r;
         endcase
      end else if (re_rise_s) begin
         case (state_r)
            ST_DOUT: ptr_n   = ptr_r + AW'(1);
            ST_ID:   idptr_n = (idptr_r == 3'd4) ? 3'd0 : idptr_r + 3'd1;
            default: ptr_n   = ptr_n;
         endcase
      end else begin
         dout_n = dout_n;
      end
      oe_n  = ((state_r == ST_DOUT) || (state_r == ST_STAT) || (state_r == ST_ID)) && !nce_s && !nre_s;
      nrb_n = !(busy_n || (rcnt_n != '0));
   end

   // State and registered pin/backend outputs.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_r <= ST_IDLE;  pend_r <= PEND_READ; acnt_r <= 3'd0; idptr_r <= 3'd0;
         addr_r  <= 40'd0;    ptr_r  <= '0;        rcnt_r <= '0;   bop_r   <= OP_READ;
         dout_r  <= 8'h00;    busy_r <= 1'b0;      fail_r <= 1'b0; oe_r    <= 1'b0;
         nrb_r   <= 1'b1;
      end else begin
         state_r <= state_n;  pend_r <= pend_n;    acnt_r <= acnt_n; idptr_r <= idptr_n;
         addr_r  <= addr_n;   ptr_r  <= ptr_n;     rcnt_r <= rcnt_n; bop_r   <= bop_n;
         dout_r  <= dout_n;   busy_r <= busy_n;    fail_r <= fail_n; oe_r    <= oe_n;
         nrb_r   <= nrb_n;
      end
   end

   // Page buffer: host data-in writes, or backend writes while an op is outstanding.
   always_ff @(posedge PCLK) begin
      if (hwe_s) begin
         buf_r[ptr_r] <= F_DIO_in;
      end else if (busy_r && B_BufWe) begin
         buf_r[B_BufAddr] <= B_BufWData;
      end
   end

   assign B_BufRData = buf_r[B_BufAddr];
   assign F_DIO_out  = dout_r;
   assign F_DIO_oe   = oe_r;
   assign F_nRB      = nrb_r;
   assign B_Req      = busy_r;
   assign B_Op       = bop_r;
   assign B_Addr     = addr_r;

endmodule

// File: tb/tb_nand_target.sv
// tb_nand_target: directed host/backend sequences with randomized columns, rows and data,
// checked against a page/ID/status model. Honours NAND_TGT_WP_EN for the write-protect step.
module tb_nand_target;

   localparam int PB = 64;

   logic       PCLK = 1'b0;
   logic       PRESET, F_nCE, F_CLE, F_ALE, F_nWE, F_nRE, F_nWP;
   logic [7:0] F_DIO_in, F_DIO_out;
   logic       F_DIO_oe, F_nRB, B_Req, B_Ack, B_Fail, B_BufWe;
   logic [1:0] B_Op;
   logic [39:0] B_Addr;
   logic [5:0] B_BufAddr;
   logic [7:0] B_BufWData, B_BufRData;

   int checks = 0;
   int errors = 0;
   logic [7:0] page [PB];
   logic [7:0] id_model [5];

   nand_target #(.PAGE_BYTES(PB), .ID_BYTES(40'h00_00_95_DA_EC), .RST_CYCLES(16)) dut (
      .PCLK(PCLK), .PRESET(PRESET), .F_nCE(F_nCE), .F_CLE(F_CLE), .F_ALE(F_ALE),
      .F_nWE(F_nWE), .F_nRE(F_nRE), .F_nWP(F_nWP), .F_DIO_in(F_DIO_in),
      .F_DIO_out(F_DIO_out), .F_DIO_oe(F_DIO_oe), .F_nRB(F_nRB), .B_Req(B_Req),
      .B_Op(B_Op), .B_Addr(B_Addr), .B_Ack(B_Ack), .B_Fail(B_Fail),
      .B_BufAddr(B_BufAddr), .B_BufWData(B_BufWData), .B_BufWe(B_BufWe),
      .B_BufRData(B_BufRData)
   );

   always #5 PCLK = ~PCLK;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] status(input logic wp, input logic rdy, input logic fail);
      return {wp, rdy, 5'b00000, fail};
   endfunction

   task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge PCLK);
   endtask

   task automatic latch(input logic c, input logic a, input logic [7:0] d);
      F_CLE = c; F_ALE = a; F_DIO_in = d;
      tick(2); F_nWE = 1'b0; tick(3); F_nWE = 1'b1; tick(6);
      F_CLE = 1'b0; F_ALE = 1'b0;
   endtask

   task automatic cmd(input logic [7:0] d);  latch(1'b1, 1'b0, d); endtask
   task automatic adr(input logic [7:0] d);  latch(1'b0, 1'b1, d); endtask
   task automatic din(input logic [7:0] d);  latch(1'b0, 1'b0, d); endtask

   task automatic read_byte(output logic [7:0] b, output logic oe);
      F_nRE = 1'b0; tick(5); b = F_DIO_out; oe = F_DIO_oe; F_nRE = 1'b1; tick(5);
   endtask

   task automatic bwrite(input logic [5:0] a, input logic [7:0] d);
      B_BufAddr = a; B_BufWData = d; B_BufWe = 1'b1; tick(1); B_BufWe = 1'b0;
   endtask

   task automatic bread(input logic [5:0] a, output logic [7:0] d);
      B_BufAddr = a; #1; d = B_BufRData;
   endtask

   task automatic ack(input logic f);
      B_Fail = f; B_Ack = 1'b1; tick(1); B_Ack = 1'b0; B_Fail = 1'b0;
   endtask

   task automatic wait_req(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         if (B_Req) ok = 1'b1;
         else tick(1);
      end
   endtask

   initial begin
      logic [7:0]  b, d;
      logic        oe, ok;
      int          col, n, cnt;
      logic [23:0] row;

      id_model[0] = 8'hEC; id_model[1] = 8'hDA; id_model[2] = 8'h95;
      id_model[3] = 8'h00; id_model[4] = 8'h00;
      PRESET = 1'b1; F_nCE = 1'b1; F_CLE = 1'b0; F_ALE = 1'b0; F_nWE = 1'b1; F_nRE = 1'b1;
      F_nWP = 1'b1; F_DIO_in = 8'h00; B_Ack = 1'b0; B_Fail = 1'b0; B_BufWe = 1'b0;
      B_BufAddr = 6'd0; B_BufWData = 8'h00;
      tick(2);
      PRESET = 1'b0;
      tick(1);
      check("rst_nrb", F_nRB, 1'b1);
      check("rst_oe", F_DIO_oe, 1'b0);
      check("rst_req", B_Req, 1'b0);
      check("rst_op", B_Op, 2'd0);
      check("rst_addr", B_Addr, 40'd0);
      check("rst_dout", F_DIO_out, 8'h00);

      // Read ID: five bytes then wrap to byte 0
      F_nCE = 1'b0; tick(2);
      cmd(8'h90); adr(8'h00);
      for (int i = 0; i < 6; i++) begin
         read_byte(b, oe);
         check("id_byte", b, id_model[i % 5]);
         check("id_oe", oe, 1'b1);
      end

      // Program with column wrap at the page end
      cmd(8'h80);
      adr(8'h3E); adr(8'h00); adr(8'h05); adr(8'h00); adr(8'h00);
      din(8'hA1); din(8'hB2); din(8'hC3);
      page[62] = 8'hA1; page[63] = 8'hB2; page[0] = 8'hC3;
      cmd(8'h10);
      wait_req(ok);
      check("prog_req", ok, 1'b1);
      check("prog_nrb", F_nRB, 1'b0);
      check("prog_op", B_Op, 2'd1);
      check("prog_addr", B_Addr, 40'h00_0005_003E);
      bread(6'h3E, b); check("prog_buf3e", b, page[62]);
      bread(6'h3F, b); check("prog_buf3f", b, page[63]);
      bread(6'h00, b); check("prog_buf00", b, page[0]);
      ack(1'b0);
      check("prog_done_nrb", F_nRB, 1'b1);
      check("prog_done_req", B_Req, 1'b0);

      // Randomized program
      col = $urandom_range(0, PB - 1); n = $urandom_range(2, 6); row = 24'($urandom);
      cmd(8'h80); adr(8'(col)); adr(8'h00); adr(row[7:0]); adr(row[15:8]); adr(row[23:16]);
      for (int i = 0; i < n; i++) begin
         d = 8'($urandom);
         page[(col + i) % PB] = d;
         din(d);
      end
      cmd(8'h10);
      wait_req(ok);
      check("rprog_req", ok, 1'b1);
      check("rprog_addr", B_Addr, {row, 16'(col)});
      ack(1'b0);
      for (int i = 0; i < n; i++) begin
         bread(6'((col + i) % PB), b);
         check("rprog_buf", b, page[(col + i) % PB]);
      end
      // Backend writes while idle are discarded
      bwrite(6'(col), ~page[col]);
      bread(6'(col), b);
      check("idle_bufwe", b, page[col]);

      // Page read: backend fills the buffer, host reads from column 0
      row = 24'($urandom);
      cmd(8'h00); adr(8'h00); adr(8'h00); adr(row[7:0]); adr(row[15:8]); adr(row[23:16]);
      cmd(8'h30);
      wait_req(ok);
      check("read_req", ok, 1'b1);
      check("read_op", B_Op, 2'd0);
      check("read_addr", B_Addr, {row, 16'h0000});
      for (int i = 0; i < PB; i++) begin
         d = (i == 0) ? 8'h5A : 8'($urandom);
         page[i] = d;
         bwrite(6'(i), d);
      end
      ack(1'b0);
      check("read_done_nrb", F_nRB, 1'b1);
      tick(2);
      for (int i = 0; i < 3; i++) begin
         read_byte(b, oe);
         check("read_byte", b, page[i]);
         check("read_oe", oe, 1'b1);
      end
      cmd(8'h70); read_byte(b, oe);
      check("read_status", b, status(1'b1, 1'b1, 1'b0));

      // Read crossing the page end
      col = $urandom_range(PB - 8, PB - 1);
      cmd(8'h00); adr(8'(col)); adr(8'h00); adr(8'h00); adr(8'h00); adr(8'h00);
      cmd(8'h30);
      wait_req(ok);
      check("wrap_req", ok, 1'b1);
      ack(1'b0);
      tick(2);
      for (int i = 0; i < 10; i++) begin
         read_byte(b, oe);
         check("wrap_byte", b, page[(col + i) % PB]);
      end

      // Erase with status polled during BUSY, then a failing completion
      cmd(8'h60); adr(8'h01); adr(8'h02); adr(8'h03); cmd(8'hD0);
      wait_req(ok);
      check("erase_req", ok, 1'b1);
      check("erase_op", B_Op, 2'd2);
      check("erase_addr", B_Addr, 40'h03_0201_0000);
      cmd(8'h70); read_byte(b, oe);
      check("busy_status", b, status(1'b1, 1'b0, 1'b0));
      F_nCE = 1'b1; tick(6); F_nCE = 1'b0; tick(2);
      check("busy_hold_req", B_Req, 1'b1);
      check("busy_hold_nrb", F_nRB, 1'b0);
      ack(1'b1);
      check("erase_done_nrb", F_nRB, 1'b1);
      cmd(8'h70); read_byte(b, oe);
      check("erase_status", b, status(1'b1, 1'b1, 1'b1));

      // Out-of-order data during address phase aborts the program
      cmd(8'h80); din(8'h55); cmd(8'h10); tick(4);
      check("ooo_req", B_Req, 1'b0);
      check("ooo_nrb", F_nRB, 1'b1);

      // Reset mid-BUSY: late ack is dropped, busy held for the reset timer
      cmd(8'h00); adr(8'h00); adr(8'h00); adr(8'h00); adr(8'h00); adr(8'h00); cmd(8'h30);
      wait_req(ok);
      check("ff_req", ok, 1'b1);
      F_CLE = 1'b1; F_DIO_in = 8'hFF; tick(2); F_nWE = 1'b0; tick(3); F_nWE = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (!B_Req) ok = 1'b1;
         else tick(1);
      end
      check("ff_req_drop", ok, 1'b1);
      cnt = 0;
      while (!F_nRB && cnt < 40) begin
         cnt++;
         B_Ack = (cnt == 3); B_Fail = (cnt == 3);
         tick(1);
      end
      B_Ack = 1'b0; B_Fail = 1'b0; F_CLE = 1'b0;
      check("ff_busy_cycles", 40'(cnt), 40'd16);
      check("ff_req_after", B_Req, 1'b0);
      cmd(8'h70); read_byte(b, oe);
      check("ff_status", b, status(1'b1, 1'b1, 1'b0));

      // Write protect pin low
      F_nWP = 1'b0; tick(4);
      cmd(8'h60); adr(8'h07); adr(8'h08); adr(8'h09); cmd(8'hD0);
`ifdef NAND_TGT_WP_EN
      tick(4);
      check("wp_erase_req", B_Req, 1'b0);
      cmd(8'h70); read_byte(b, oe);
      check("wp_status", b, status(1'b0, 1'b1, 1'b0));
`else
      wait_req(ok);
      check("nowp_erase_req", ok, 1'b1);
      ack(1'b0);
      cmd(8'h70); read_byte(b, oe);
      check("nowp_status", b, status(1'b1, 1'b1, 1'b0));
`endif
      col = $urandom_range(0, PB - 1); n = $urandom_range(1, 4);
      cmd(8'h80); adr(8'(col)); adr(8'h00); adr(8'h00); adr(8'h00); adr(8'h00);
      for (int i = 0; i < n; i++) din(~page[(col + i) % PB]);
      cmd(8'h10);
`ifdef NAND_TGT_WP_EN
      tick(4);
      check("wp_prog_req", B_Req, 1'b0);
`else
      wait_req(ok);
      check("nowp_prog_req", ok, 1'b1);
      ack(1'b0);
      for (int i = 0; i < n; i++) page[(col + i) % PB] = ~page[(col + i) % PB];
`endif
      for (int i = 0; i < n; i++) begin
         bread(6'((col + i) % PB), b);
         check("wp_buf", b, page[(col + i) % PB]);
      end
      F_nWP = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
